otp_stream_ctrl: RTL

//  Controller and XOR stage downstream of the key shifter in the OTP cypher datapath.

---
 rtl/otp_stream_ctrl_pkg.sv | 23 ++
 rtl/otp_stream_ctrl_if.sv | 28 ++
 rtl/otp_stream_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/otp_stream_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the OTP stream controller.
// The key shifter and the XOR stage both use these widths.
package otp_stream_ctrl_pkg;

  localparam int OTP_MSG_SIZE = 32;
  localparam int OTP_KEY_SIZE = 32;
  localparam int OTP_WARMUP   = 4;
  localparam int OTP_OFS_W    = 16;
  localparam int OTP_CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_WARMUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } otp_state_e;

  function automatic logic is_last_word(input logic [OTP_CNT_W-1:0] rem);
    return rem == OTP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/otp_stream_ctrl_if.sv
// Plaintext-in / ciphertext-out handshake bundle for the OTP stream controller.
// The slave side is the controller; the master side is whoever feeds and drains it.
interface otp_stream_ctrl_if #(
  parameter int MSG_SIZE = otp_stream_ctrl_pkg::OTP_MSG_SIZE,
  parameter int OFS_W    = otp_stream_ctrl_pkg::OTP_OFS_W
) ();

  logic                msg_valid;
  logic [MSG_SIZE-1:0] msg_data;
  logic                msg_ready;

  logic                ct_valid;
  logic [MSG_SIZE-1:0] ct_data;
  logic [OFS_W-1:0]    ct_offset;
  logic                ct_last;
  logic                ct_ready;

  modport master (
    output msg_valid, msg_data, ct_ready,
    input  msg_ready, ct_valid, ct_data, ct_offset, ct_last
  );

  modport slave (
    input  msg_valid, msg_data, ct_ready,
    output msg_ready, ct_valid, ct_data, ct_offset, ct_last
  );

endinterface

// File: rtl/otp_stream_ctrl.sv
// Seeds the key shifter, waits for the key stream to warm up, then XORs each accepted
// plaintext word with the current key and tags it with the key offset for decryption.
module otp_stream_ctrl
  import otp_stream_ctrl_pkg::*;
#(
  parameter int MSG_SIZE = OTP_MSG_SIZE,
  parameter int KEY_SIZE = OTP_KEY_SIZE,
  parameter int WARMUP   = OTP_WARMUP,
  parameter int OFS_W    = OTP_OFS_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [MSG_SIZE-1:0]  i_seed,
  input  logic [OTP_CNT_W-1:0] i_num_words,
  output logic                 o_key_load,
  output logic [MSG_SIZE-1:0]  o_seed_out,
  input  logic [KEY_SIZE-1:0]  i_key_in,
  output logic                 o_busy,
  output logic                 o_done,
  otp_stream_ctrl_if.slave     io_strm
);

  otp_state_e             r_state;
  logic                   r_key_load;
  logic [MSG_SIZE-1:0]    r_seed;
  logic                   r_busy;
  logic                   r_done;
  logic [OFS_W-1:0]       r_tick;
  logic [OTP_CNT_W-1:0]   r_remaining;

  logic                   r_ct_vld_p1;
  logic [MSG_SIZE-1:0]    r_ct_data_p1;
  logic [OFS_W-1:0]       r_ct_ofs_p1;
  logic                   r_ct_last_p1;

  logic                   w_rem_zero;
  logic                   w_ct_free;
  logic                   w_msg_ready;
  logic                   w_accept;
  logic                   w_ct_hs;

  function automatic logic [MSG_SIZE-1:0] otp_mix(
    input logic [MSG_SIZE-1:0] msg,
    input logic [KEY_SIZE-1:0] key
  );
    return msg ^ key[MSG_SIZE-1:0];
  endfunction

  assign w_rem_zero  = (r_remaining == '0);
  // The output slot is free if empty or being drained this cycle.
  assign w_ct_free   = !r_ct_vld_p1 || io_strm.ct_ready;
  assign w_msg_ready = (r_state == ST_RUN) && !w_rem_zero && w_ct_free;
  assign w_accept    = io_strm.msg_valid && w_msg_ready;
  assign w_ct_hs     = r_ct_vld_p1 && io_strm.ct_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_key_load  <= 1'b0;
      r_seed      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tick      <= '0;
      r_remaining <= '0;
    end else begin
      r_key_load <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state     <= ST_SEED;
            r_seed      <= i_seed;
            r_remaining <= i_num_words;
            r_key_load  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_SEED: begin
          r_tick  <= '0;
          r_state <= ST_WARMUP;
        end
        ST_WARMUP: begin
          // The tick doubles as the warm-up counter since it restarts at zero here.
          r_tick <= r_tick + 1'b1;
          if (r_tick == OFS_W'(WARMUP - 1)) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_tick <= r_tick + 1'b1;
          if (w_accept) r_remaining <= r_remaining - 1'b1;
          if (w_rem_zero && w_ct_free) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_tick  <= r_tick + 1'b1;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: ciphertext output register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ct_vld_p1  <= 1'b0;
      r_ct_data_p1 <= '0;
      r_ct_ofs_p1  <= '0;
      r_ct_last_p1 <= 1'b0;
    end else if (w_accept) begin
      r_ct_vld_p1  <= 1'b1;
      r_ct_data_p1 <= otp_mix(io_strm.msg_data, i_key_in);
      r_ct_ofs_p1  <= r_tick;
      r_ct_last_p1 <= is_last_word(r_remaining);
    end else if (w_ct_hs) begin
      r_ct_vld_p1  <= 1'b0;
      r_ct_last_p1 <= 1'b0;
    end
  end

  assign o_key_load        = r_key_load;
  assign o_seed_out        = r_seed;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign io_strm.msg_ready = w_msg_ready;
  assign io_strm.ct_valid  = r_ct_vld_p1;
  assign io_strm.ct_data   = r_ct_data_p1;
  assign io_strm.ct_offset = r_ct_ofs_p1;
  assign io_strm.ct_last   = r_ct_last_p1;

endmodule
